fwft_rr_arbiter: RTL and testbench

// - Shares one downstream valid/ready consumer between NUM_SRC FWFT FIFOs (fwft_fifo read side).
// - Round-robin arbitration, burst-locked: the granted source keeps the output for up to MAX_BURST beats.
// - Drives each FIFO's rd_en directly. Sits between the per-requester FWFT FIFOs and the shared NoC/NOU egress datapath.

---
 rtl/fwft_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_fwft_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_rr_arbiter.sv
// fwft_rr_arbiter
// Shares one downstream valid/ready consumer between NUM_SRC first-word-fall-through
// FIFOs. Sources are granted round-robin and a grant is held for up to MAX_BURST beats.
// The arbiter pops the granted FIFO directly through its rd_en.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous reset, active-high
//   src_empty_i  per-source FWFT empty flag
//   src_dout_i   per-source FWFT head word, source i at [i*WIDTH +: WIDTH]
//   src_rd_en_o  per-source pop, one-hot or zero
//   out_valid_o  output beat valid
//   out_ready_i  downstream accepts beat
//   out_data_o   beat data, zero when out_valid_o is low
//   out_src_o    index of the granted source
//   out_last_o   beat is the MAX_BURST-th of the grant, qualified by out_valid_o
module fwft_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int WIDTH     = 512,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_empty_i,
  input  logic [NUM_SRC*WIDTH-1:0]   src_dout_i,
  output logic [NUM_SRC-1:0]         src_rd_en_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(NUM_SRC)-1:0] out_src_o,
  output logic                       out_last_o
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           state_q;
  logic [SRC_W-1:0] grant_q;
  logic [SRC_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] beat_cnt_q;

  logic             found;
  logic [SRC_W-1:0] winner;
  logic [SRC_W-1:0] winner_next_ptr;
  logic             cur_empty;
  logic             transfer;
  logic             at_limit;
  logic             burst_end;
  logic [SRC_W:0]   probe;

  // Round-robin search starting at rr_ptr_q. The probe index is kept one bit
  // wider so the modulo wrap works for non-power-of-two source counts.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    probe  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      probe = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (probe >= (SRC_W+1)'(NUM_SRC)) begin
        probe = probe - (SRC_W+1)'(NUM_SRC);
      end
      if (!found && !src_empty_i[probe[SRC_W-1:0]]) begin
        found  = 1'b1;
        winner = probe[SRC_W-1:0];
      end
    end
  end

  // Pointer for the next search starts just after the winner.
  always_comb begin
    if (winner == SRC_W'(NUM_SRC - 1)) begin
      winner_next_ptr = '0;
    end else begin
      winner_next_ptr = winner + SRC_W'(1);
    end
  end

  // Datapath of the current grant. Outputs come straight from the held grant
  // and the source flags, so an asynchronous reset clears them at once.
  always_comb begin
    cur_empty   = src_empty_i[grant_q];
    out_valid_o = (state_q == BURST) && !cur_empty;
    transfer    = out_valid_o && out_ready_i;
    at_limit    = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
    out_last_o  = out_valid_o && at_limit;
    burst_end   = (state_q == BURST) && (cur_empty || (transfer && at_limit));
    out_src_o   = grant_q;
  end

  // Head-word mux; constant-index slices keep the select width clean.
  always_comb begin
    out_data_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (out_valid_o && (grant_q == SRC_W'(i))) begin
        out_data_o = src_dout_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pop only the granted FIFO, and only on an accepted beat.
  always_comb begin
    src_rd_en_o = '0;
    if (transfer) begin
      src_rd_en_o[grant_q] = 1'b1;
    end
  end

  // Grant FSM. A burst that ends re-arbitrates in the same cycle, which is what
  // gives the zero-bubble handover at the beat limit. The ending source is still
  // non-empty in that cycle even if this was its last word, so it may be
  // re-granted and then release through the drained path one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q    <= BURST;
            grant_q    <= winner;
            rr_ptr_q   <= winner_next_ptr;
            beat_cnt_q <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            if (found) begin
              state_q    <= BURST;
              grant_q    <= winner;
              rr_ptr_q   <= winner_next_ptr;
              beat_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else if (transfer) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwft_rr_arbiter.sv
// tb_fwft_rr_arbiter
// Drives two arbiter instances: a 4-source, 4-beat instance fed by simple FWFT
// FIFO models, and a 3-source, 1-beat instance with permanently full sources.
// Head words of the 4-source FIFOs encode {source, pop count} so every beat's
// data identifies where it came from and which word it is.
module tb_fwft_rr_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 4-source instance
  logic [3:0]   src_empty4;
  logic [4*W-1:0] src_dout4;
  logic [3:0]   rd_en4;
  logic         valid4;
  logic         ready4 = 1'b0;
  logic [W-1:0] data4;
  logic [1:0]   src4;
  logic         last4;

  // 3-source instance
  logic [2:0]   src_empty3;
  logic [3*W-1:0] src_dout3;
  logic [2:0]   rd_en3;
  logic         valid3;
  logic         ready3 = 1'b0;
  logic [W-1:0] data3;
  logic [1:0]   src3;
  logic         last3;

  int pushed [4];
  int popped [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          start;
    logic [15:0] load;
    bit          ready;
    bit          exp_valid;
    int          exp_src;
    bit          exp_last;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fwft_rr_arbiter #(.NUM_SRC(4), .WIDTH(W), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst),
    .src_empty_i(src_empty4), .src_dout_i(src_dout4), .src_rd_en_o(rd_en4),
    .out_valid_o(valid4), .out_ready_i(ready4), .out_data_o(data4),
    .out_src_o(src4), .out_last_o(last4)
  );

  fwft_rr_arbiter #(.NUM_SRC(3), .WIDTH(W), .MAX_BURST(1)) dut3 (
    .clk(clk), .rst(rst),
    .src_empty_i(src_empty3), .src_dout_i(src_dout3), .src_rd_en_o(rd_en3),
    .out_valid_o(valid3), .out_ready_i(ready3), .out_data_o(data3),
    .out_src_o(src3), .out_last_o(last3)
  );

  // FIFO models for the 4-source instance: occupancy is pushes minus pops.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_empty4[i]         = (pushed[i] == popped[i]);
      src_dout4[i*W +: W]   = {16'(i), 16'(popped[i])};
    end
  end

  // Pops land on the rising edge, exactly as a FWFT read port would.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rd_en4[i]) popped[i] <= popped[i] + 1;
    end
  end

  // The 3-source instance always sees full sources with fixed head words.
  assign src_empty3 = 3'b000;
  assign src_dout3  = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks one cycle of the 4-source instance against expected beat fields.
  task automatic check_output(input string name, input bit exp_valid, input int exp_src,
                              input bit exp_last, input bit rdy);
    logic [3:0]   exp_rd;
    logic [W-1:0] exp_data;
    exp_rd   = (exp_valid && rdy) ? 4'(1 << exp_src) : 4'b0000;
    exp_data = exp_valid ? {16'(exp_src), 16'(popped[exp_src])} : '0;
    check_val({name, " valid"}, 64'(valid4), 64'(exp_valid));
    check_val({name, " last"},  64'(last4),  64'(exp_last));
    check_val({name, " rd_en"}, 64'(rd_en4), 64'(exp_rd));
    check_val({name, " data"},  64'(data4),  64'(exp_data));
    if (exp_valid) check_val({name, " src"}, 64'(src4), 64'(exp_src));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_vec(input bit start, input logic [15:0] load, input bit rdy,
                         input bit v, input int s, input bit l, input string name);
    vec_t t;
    t.start = start; t.load = load; t.ready = rdy;
    t.exp_valid = v; t.exp_src = s; t.exp_last = l; t.name = name;
    vecs.push_back(t);
  endtask

  // Runs the vector table; a start record resets, loads the FIFOs and waits
  // for the one-cycle arbitration latency before its own cycle is checked.
  task automatic apply_stimulus();
    foreach (vecs[n]) begin
      if (vecs[n].start) begin
        ready4 = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) pushed[i] += int'(vecs[n].load[i*4 +: 4]);
        @(posedge clk);
        @(negedge clk);
      end
      ready4 = vecs[n].ready;
      #1;
      check_output($sformatf("%s[%0d]", vecs[n].name, n), vecs[n].exp_valid,
                   vecs[n].exp_src, vecs[n].exp_last, vecs[n].ready);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int saved;
    $display("[TB] start");

    // T1: src2 holds 6 words
    add_vec(1, 16'h0600, 1, 1, 2, 0, "t1");
    add_vec(0, 0, 1, 1, 2, 0, "t1");
    add_vec(0, 0, 1, 1, 2, 0, "t1");
    add_vec(0, 0, 1, 1, 2, 1, "t1");
    add_vec(0, 0, 1, 1, 2, 0, "t1");
    add_vec(0, 0, 1, 1, 2, 0, "t1");
    add_vec(0, 0, 1, 0, 0, 0, "t1");
    add_vec(0, 0, 1, 0, 0, 0, "t1");

    // T2: all four sources hold 5 words
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 4; b++) begin
        add_vec((s == 0 && b == 0), 16'h5555, 1, 1, s, (b == 3), "t2");
      end
    end
    for (int s = 0; s < 4; s++) begin
      add_vec(0, 0, 1, 1, s, 0, "t2tail");
      add_vec(0, 0, 1, 0, 0, 0, "t2tail");
    end
    add_vec(0, 0, 1, 0, 0, 0, "t2tail");

    // T3: backpressure on src0 with 4 words
    add_vec(1, 16'h0004, 1, 1, 0, 0, "t3");
    add_vec(0, 0, 1, 1, 0, 0, "t3");
    for (int c = 0; c < 5; c++) add_vec(0, 0, 0, 1, 0, 0, "t3stall");
    add_vec(0, 0, 1, 1, 0, 0, "t3");
    add_vec(0, 0, 0, 1, 0, 1, "t3stall");
    add_vec(0, 0, 0, 1, 0, 1, "t3stall");
    add_vec(0, 0, 1, 1, 0, 1, "t3");
    add_vec(0, 0, 1, 0, 0, 0, "t3");
    add_vec(0, 0, 1, 0, 0, 0, "t3");

    // T4: early drain, src1 x2 then src3 x4
    add_vec(1, 16'h4020, 1, 1, 1, 0, "t4");
    add_vec(0, 0, 1, 1, 1, 0, "t4");
    add_vec(0, 0, 1, 0, 0, 0, "t4");
    add_vec(0, 0, 1, 1, 3, 0, "t4");
    add_vec(0, 0, 1, 1, 3, 0, "t4");
    add_vec(0, 0, 1, 1, 3, 0, "t4");
    add_vec(0, 0, 1, 1, 3, 1, "t4");
    add_vec(0, 0, 1, 0, 0, 0, "t4");
    add_vec(0, 0, 1, 0, 0, 0, "t4");

    // Reset state of both instances
    #1;
    check_val("reset valid4", 64'(valid4), 64'd0);
    check_val("reset rd_en4", 64'(rd_en4), 64'd0);
    check_val("reset src4",   64'(src4),   64'd0);
    check_val("reset valid3", 64'(valid3), 64'd0);

    apply_stimulus();

    // T5: reset after beat 2 of a src0 burst
    ready4 = 1'b0;
    do_reset();
    pushed[0] += 6;
    pushed[1] += 3;
    @(posedge clk);
    @(negedge clk);
    ready4 = 1'b1;
    #1 check_output("t5 beat1", 1, 0, 0, 1);
    @(posedge clk); @(negedge clk);
    #1 check_output("t5 beat2", 1, 0, 0, 1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    saved = popped[0];
    #1;
    check_val("t5 rst valid", 64'(valid4), 64'd0);
    check_val("t5 rst rd_en", 64'(rd_en4), 64'd0);
    check_val("t5 rst data",  64'(data4),  64'd0);
    check_val("t5 rst last",  64'(last4),  64'd0);
    check_val("t5 rst src",   64'(src4),   64'd0);
    @(posedge clk); @(negedge clk);
    check_val("t5 no pop", 64'(popped[0]), 64'(saved));
    rst = 1'b0;
    #1 check_output("t5 idle", 0, 0, 0, 1);
    @(posedge clk); @(negedge clk);
    #1 check_output("t5 regrant", 1, 0, 0, 1);
    ready4 = 1'b0;

    // T6: 3 sources, one beat per grant
    @(negedge clk);
    ready3 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_val($sformatf("t6 valid[%0d]", c), 64'(valid3), 64'd1);
      check_val($sformatf("t6 src[%0d]", c),   64'(src3),   64'(c % 3));
      check_val($sformatf("t6 last[%0d]", c),  64'(last3),  64'd1);
      check_val($sformatf("t6 rd_en[%0d]", c), 64'(rd_en3), 64'(1 << (c % 3)));
      check_val($sformatf("t6 data[%0d]", c),  64'(data3),  64'(32'hC0 + (c % 3)));
      @(posedge clk);
      @(negedge clk);
    end
    ready3 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
